// File: rtl/led_cons_axil_slave.sv
// AXI4-Lite slave for LED_CONS: four word registers (PATTERN, MODE, PERIOD, SCRATCH) driving led_o.
// Define LED_CONS_ENGINE_EN to build the prescaler and blink/shift engine; otherwise led_o follows PATTERN.
module led_cons_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int LED_W              = 8
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [LED_W-1:0]              led_o
);

  localparam logic [1:0] RESP_OKAY = 2'b00;

  logic [31:0]      regs [4];
  logic             aw_full, w_full, bvalid, rvalid;
  logic [1:0]       aw_idx;
  logic [31:0]      w_data, rdata;
  logic [3:0]       w_strb;
  logic             aw_hs, w_hs, ar_hs, commit;
  logic [1:0]       wr_idx;
  logic [31:0]      wr_data, wr_merged;
  logic [3:0]       wr_strb;
  logic [LED_W-1:0] led_q, led_nxt;
  logic             unused_bits;

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  // Readies are forced low while reset is held, not just after the first edge.
  assign S_AXI_AWREADY = ARESETN && !aw_full && !bvalid;
  assign S_AXI_WREADY  = ARESETN && !w_full && !bvalid;
  assign S_AXI_ARREADY = ARESETN && !rvalid;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign led_o         = led_q;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  // Commit in the same cycle the second half arrives, bypassing its holding buffer.
  assign commit = (aw_full || aw_hs) && (w_full || w_hs);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    wr_idx    = aw_full ? aw_idx : S_AXI_AWADDR[3:2];
    wr_data   = w_full ? w_data : S_AXI_WDATA;
    wr_strb   = w_full ? w_strb : S_AXI_WSTRB;
    wr_merged = regs[wr_idx];
    for (int b = 0; b < 4; b++)
      if (wr_strb[b]) wr_merged[8*b +: 8] = wr_data[8*b +: 8];
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      // NOTE: the register file is software-visible and must read 0 after reset, so it is reset.
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      if (commit) begin
        regs[wr_idx] <= wr_merged;
        aw_full      <= 1'b0;
        w_full       <= 1'b0;
        bvalid       <= 1'b1;
      end else begin
        if (aw_hs) begin
          aw_full <= 1'b1;
          aw_idx  <= S_AXI_AWADDR[3:2];
        end
        if (w_hs) begin
          w_full <= 1'b1;
          w_data <= S_AXI_WDATA;
          w_strb <= S_AXI_WSTRB;
        end
        if (bvalid && S_AXI_BREADY) bvalid <= 1'b0;
      end

      // Reads sample the pre-commit register value when both land in one cycle.
      if (ar_hs) begin
        rdata  <= regs[S_AXI_ARADDR[3:2]];
        rvalid <= 1'b1;
      end else if (rvalid && S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

`ifdef LED_CONS_ENGINE_EN
  typedef enum logic [1:0] {MODE_STATIC, MODE_BLINK, MODE_SHIFT, MODE_OFF} led_mode_e;

  logic [31:0]      presc;
  logic             blink_off, tick, cfg_write;
  logic [LED_W-1:0] shift_q, pattern_nxt;

  assign tick        = (presc == regs[2]);
  assign cfg_write   = commit && (wr_idx != 2'd3);
  assign pattern_nxt = (commit && wr_idx == 2'd0) ? wr_merged[LED_W-1:0] : regs[0][LED_W-1:0];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      presc     <= '0;
      blink_off <= 1'b0;
      shift_q   <= '0;
    end else if (cfg_write) begin
      presc     <= '0;
      blink_off <= 1'b0;
      shift_q   <= pattern_nxt;
    end else if (tick) begin
      presc     <= '0;
      blink_off <= !blink_off;
      shift_q   <= (shift_q << 1) | (shift_q >> (LED_W - 1));
    end else begin
      presc <= presc + 32'd1;
    end
  end

  always_comb begin
    led_nxt = '0;
    case (led_mode_e'(regs[1][1:0]))
      MODE_STATIC: led_nxt = regs[0][LED_W-1:0];
      MODE_BLINK:  led_nxt = blink_off ? '0 : regs[0][LED_W-1:0];
      MODE_SHIFT:  led_nxt = shift_q;
      default:     led_nxt = '0;
    endcase
  end
`else
  assign led_nxt = regs[0][LED_W-1:0];
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) led_q <= '0;
    else          led_q <= led_nxt;
  end

endmodule

// File: tb/tb_led_cons_axil_slave.sv
// Randomized self-checking bench for led_cons_axil_slave against a closed-form register/LED model.
// LED expectations follow the engine rules when LED_CONS_ENGINE_EN is defined, else led = PATTERN.
module tb_led_cons_axil_slave;

  localparam int LW = 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [3:0]    awaddr = '0, araddr = '0;
  logic [2:0]    awprot = '0, arprot = '0;
  logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;
  logic [LW-1:0] led;

  int          n_vec = 0, n_err = 0;
  longint      cyc = 0, cfg_cyc = 0;
  logic [31:0] mreg [4];
  bit          mon_en = 1'b0;

  led_cons_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .LED_W(LW)) dut (
    .ACLK(aclk), .ARESETN(aresetn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .led_o(led)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // LED after m edges past the last config write: ticks seen by led_o = (m-1)/(PERIOD+1).
  function automatic logic [LW-1:0] model_led(input longint m);
    logic [LW-1:0] p = mreg[0][LW-1:0];
    longint        per = longint'(mreg[2]);
    longint        n = (m - 1) / (per + 1);
    logic [LW-1:0] r = p;
`ifdef LED_CONS_ENGINE_EN
    case (mreg[1][1:0])
      2'd0: return p;
      2'd1: return (n % 2 == 0) ? p : '0;
      2'd2: begin
        for (int k = 0; k < int'(n % LW); k++) r = {r[LW-2:0], r[LW-1]};
        return r;
      end
      default: return '0;
    endcase
`else
    return p;
`endif
  endfunction

  always @(negedge aclk)
    if (mon_en && (cyc - cfg_cyc) >= 1) check("led", 32'(led), 32'(model_led(cyc - cfg_cyc)));

  task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    for (int b = 0; b < 4; b++)
      if (strb[b]) mreg[addr[3:2]][8*b +: 8] = data[8*b +: 8];
    if (addr[3:2] != 2'd3) cfg_cyc = cyc;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mreg[i] = '0;
    cfg_cyc = cyc;
  endtask

  task automatic step();
    @(posedge aclk); #1;
  endtask

  // w_lead > 0: W offered that many cycles before AW; < 0: AW first. While B is held,
  // a stray AW/W is offered that must not be accepted.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_lead, input int b_delay);
    bit aw_done = 0, w_done = 0, aw_acc, w_acc;
    int t = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    while (!(aw_done && w_done) && t < 40) begin
      awvalid = !aw_done && (t >= (w_lead > 0 ? w_lead : 0));
      wvalid  = !w_done && (t >= (w_lead < 0 ? -w_lead : 0));
      @(negedge aclk);
      check("bvalid_early", 32'(bvalid), 0);
      if (w_done) check("wready_buf_full", 32'(wready), 0);
      if (aw_done) check("awready_buf_full", 32'(awready), 0);
      aw_acc = awvalid && awready;
      w_acc  = wvalid && wready;
      @(posedge aclk); #1;
      aw_done |= aw_acc;
      w_done  |= w_acc;
      t++;
    end
    awvalid = 0; wvalid = 0;
    check("wr_handshake", {30'd0, aw_done, w_done}, 32'd3);
    model_write(addr, data, strb);
    check("b_latency", 32'(bvalid), 1);
    check("bresp", 32'(bresp), 0);
    if (b_delay > 0) begin
      awaddr = 4'hC; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    end
    for (int i = 0; i < b_delay; i++) begin
      step();
      check("bvalid_hold", 32'(bvalid), 1);
      check("ready_during_b", {30'd0, awready, wready}, 0);
    end
    bready = 1;
    step();
    bready = 0; awvalid = 0; wvalid = 0;
    check("bvalid_clear", 32'(bvalid), 0);
  endtask

  task automatic axi_read(input logic [3:0] addr, input int r_delay, output logic [31:0] data);
    bit acc = 0;
    int t = 0;
    arvalid = 1; araddr = addr;
    while (!acc && t < 40) begin
      @(negedge aclk);
      acc = arready;
      step();
      t++;
    end
    arvalid = 0;
    check("ar_handshake", 32'(acc), 1);
    check("r_latency", 32'(rvalid), 1);
    check("rresp", 32'(rresp), 0);
    data = rdata;
    for (int i = 0; i < r_delay; i++) begin
      step();
      check("rdata_hold", rdata, data);
    end
    rready = 1;
    step();
    rready = 0;
    check("rvalid_clear", 32'(rvalid), 0);
  endtask

  task automatic read_check(input string tag, input logic [3:0] addr, input int r_delay);
    logic [31:0] d;
    axi_read(addr, r_delay, d);
    check(tag, d, mreg[addr[3:2]]);
  endtask

  initial begin
    logic [31:0] d, old;
    model_reset();
    repeat (3) step();
    check("rst_awready", 32'(awready), 0);
    check("rst_arready", 32'(arready), 0);
    check("rst_bvalid", 32'(bvalid), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_rdata", rdata, 0);
    check("rst_led", 32'(led), 0);
    aresetn = 1;
    model_reset();
    mon_en = 1;
    step();
    check("post_rst_ready", {29'd0, awready, wready, arready}, 32'd7);

    // Sequential writes and read-back
    for (int i = 0; i < 4; i++) axi_write(4'(4 * i), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) read_check("seq_read", 4'(4 * i), 0);

    // W three cycles ahead of AW, B held for five cycles with a stray request pending
    axi_write(4'h4, 32'h0000_0000, 4'hF, 3, 5);
    read_check("scratch_after_stray", 4'hC, 1);

    // Byte strobes
    axi_write(4'hC, 32'hFFFF_FFFF, 4'hF, 0, 0);
    axi_write(4'hC, 32'h0000_00AB, 4'h1, -2, 1);
    axi_read(4'hC, 0, d);
    check("strb_merge", d, 32'hFFFF_FFAB);

    // LED engine: shift then blink
    axi_write(4'h0, 32'h81, 4'hF, 0, 0);
    axi_write(4'h8, 32'h3, 4'hF, 0, 0);
    axi_write(4'h4, 32'h2, 4'hF, 0, 0);
    repeat (24) step();
    axi_write(4'h4, 32'h1, 4'hF, 0, 0);
    repeat (24) step();

    // Read and write commit in the same cycle to PERIOD
    axi_write(4'h8, 32'h5, 4'hF, 0, 0);
    awaddr = 4'h8; wdata = 32'h9; wstrb = 4'hF; araddr = 4'h8;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(negedge aclk);
    check("same_cycle_ready", {29'd0, awready, wready, arready}, 32'd7);
    step();
    awvalid = 0; wvalid = 0; arvalid = 0;
    old = mreg[2];
    model_write(4'h8, 32'h9, 4'hF);
    check("same_cycle_bvalid", 32'(bvalid), 1);
    check("same_cycle_rvalid", 32'(rvalid), 1);
    check("same_cycle_old", rdata, old);
    bready = 1; rready = 1;
    step();
    bready = 0; rready = 0;
    read_check("same_cycle_new", 4'h8, 0);

    // Randomized traffic
    for (int it = 0; it < 150; it++) begin
      logic [3:0] a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        logic [31:0] v = (a[3:2] == 2'd2) ? 32'($urandom_range(0, 5)) : $urandom;
        axi_write(a, v, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3,
                  int'($urandom_range(0, 3)));
      end else begin
        read_check("rand_read", a, int'($urandom_range(0, 3)));
      end
      repeat ($urandom_range(0, 6)) step();
    end

    // Reset while a read response is pending
    axi_write(4'h0, 32'h5A, 4'hF, 0, 0);
    arvalid = 1; araddr = 4'h0;
    step();
    arvalid = 0;
    check("pre_rst_rvalid", 32'(rvalid), 1);
    #2 aresetn = 0; mon_en = 0;
    #1;
    check("mid_rst_rvalid", 32'(rvalid), 0);
    check("mid_rst_led", 32'(led), 0);
    check("mid_rst_arready", 32'(arready), 0);
    repeat (2) step();
    aresetn = 1;
    model_reset();
    mon_en = 1;
    step();
    for (int i = 0; i < 4; i++) read_check("post_rst_read", 4'(4 * i), 0);
    repeat (4) step();

    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/led_cons_axil_slave.md
# led_cons_axil_slave

AXI4-Lite responder for the LED_CONS peripheral: the slave end of the S00_AXI interface that the master VIP bench drives. Holds four 32-bit software-visible registers (pattern, mode, period, scratch) and drives an LED output bus from them through a small timed pattern engine. Sits inside the LED_CONS IP between the block-design AXI interconnect and the board LED pins.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; decodes 4 word registers.
- LED_W, 8, number of LED outputs (1..32).

Ports:
- ACLK  in  1  single clock; all logic is rising-edge.
- ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR / AWPROT / AWVALID / AWREADY  in/in/in/out  ADDR_W/3/1/1  write address channel; AWPROT is ignored.
- S_AXI_WDATA / WSTRB / WVALID / WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_AXI_BRESP / BVALID / BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR / ARPROT / ARVALID / ARREADY  in/in/in/out  ADDR_W/3/1/1  read address channel; ARPROT is ignored.
- S_AXI_RDATA / RRESP / RVALID / RREADY  out/out/out/in  32/2/1/1  read data channel.
- led_o  out  LED_W  LED drive, active-high.

## Operation
- Register map (word index = addr[3:2]; addr[1:0] ignored): 0x0 PATTERN, 0x4 MODE (bits[1:0]; bits[31:2] stored, no function), 0x8 PERIOD, 0xC SCRATCH. All four are fully read/write; a read returns the last written value.
- Write path: AW and W are accepted independently and in either order into one-deep holding buffers. AWREADY = AW buffer empty and BVALID low; WREADY = W buffer empty and BVALID low. When both buffers are full, the commit occurs: the register bytes selected by WSTRB are updated, both buffers clear, BVALID rises. BVALID holds until BREADY; BRESP is always 2'b00 (OKAY).
- Read path: ARREADY = !RVALID. On AR handshake, RDATA captures the addressed register and RVALID rises; RDATA/RVALID hold until RREADY. RRESP is always 2'b00.
- Read and write commit in the same cycle to the same register: read returns the pre-write value.
- LED engine modes (MODE[1:0]): 0 STATIC, led_o = PATTERN[LED_W-1:0]; 1 BLINK, led_o alternates PATTERN / 0 each tick; 2 SHIFT, internal copy loaded from PATTERN then rotated left by 1 each tick; 3 OFF, led_o = 0.
- Tick: 32-bit prescaler counts 0..PERIOD, tick when count == PERIOD, then wraps to 0. PERIOD = 0 gives a tick every cycle. Any committed write to MODE, PERIOD or PATTERN clears the prescaler, the blink phase (to "on") and reloads the shift copy from PATTERN.

## Timing
- Reset values: all registers 0; AWREADY, WREADY, ARREADY = 1 after reset deassert (0 while ARESETN low); BVALID, RVALID = 0; BRESP, RRESP, RDATA = 0; led_o = 0; prescaler, phase, shift copy = 0.
- Write latency: AW and W handshake in cycle N (same or different cycles, later of the two = N) -> register updated and BVALID = 1 in N+1. A new AW/W is accepted no earlier than the cycle after the B handshake.
- Read latency: AR handshake in cycle N -> RVALID = 1 with data in N+1. Back-to-back reads with RREADY tied high: one read per 2 cycles.
- led_o is registered: reflects a register or tick change one cycle after it takes effect.
- Reset asserted mid-transaction: all channels abort, outstanding BVALID/RVALID drop immediately; no partial write is committed.

## Configuration
- LED_CONS_ENGINE_EN defined: MODE/PERIOD behaviour and prescaler as described.
- Not defined: prescaler and engine removed; led_o = PATTERN[LED_W-1:0] registered; MODE and PERIOD remain plain read/write storage with identical bus behaviour.

## Test plan
- Sequential write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back -> reads return 0x1..0x4, every BRESP/RRESP = OKAY.
- W presented 3 cycles before AW, BREADY held low 5 cycles -> single commit, BVALID held stable, no second AW/W accepted until B handshake.
- Write 0xFFFFFFFF then write 0x000000AB with WSTRB=4'b0001 to 0xC -> read returns 0xFFFFFFAB.
- PATTERN=0x81, PERIOD=3, MODE=2 -> led_o rotates 0x81 -> 0x03 -> 0x06 every 4 cycles; MODE=1 -> toggles 0x81/0x00 every 4 cycles.
- Same-cycle AR and write commit to 0x8 (old 0x5, new 0x9) -> RDATA = 0x5; next read = 0x9.
- ARESETN pulsed low while RVALID high and RREADY low -> RVALID = 0, led_o = 0, all registers read 0 afterwards.
